mmu: RTL and testbench
======================

// Module: mmu
// PURPOSE
//  Memory/IO unit on the core's im_*/dm_* side. Routes fetches to instruction RAM.
//  Routes loads/stores to data RAM or MMIO. Lane-aligns and sign-extends load data.
//  Owns the machine timer (mtime/mtimecmp -> irq_mtimecmp), the fence_i handshake and
//  the post-reset boot release.
// PARAMETERS
//  RAM_AW       12          word-address width of the instruction and data RAM ports
//  BOOT_DELAY   16          cycles after reset release before boot asserts (1..65535)
//  FENCE_CYCLES 2           FLUSH-state cycles before fence_i_done (>=1)
//  TICK_DIV     1           clk cycles per mtime increment (>=1)
// PORTS
//  clk           in   1       clock
//  resetb        in   1       synchronous reset, active-low
//  boot          out  1       core may fetch/execute; 0 = core holds PC and bubbles
//  im_addr       in   32      fetch byte address (combinational from core)
//  im_do         out  32      fetched instruction = imem_rdata (1-cycle RAM latency)
//  dm_addr       in   32      load/store byte address, FD cycle
//  dm_di         in   32      store data, unshifted rs2
//  dm_be         in   4       lane-aligned byte enables; 0 = no access
//  dm_we         in   1       store when 1, load when 0 (qualified by dm_be!=0)
//  dm_is_signed  in   1       sign-extend load
//  dm_do         out  32      load result, valid the cycle after dm_addr
//  fence_i       in   1       FD instruction is FENCE.I
//  fence_i_done  out  1       one-cycle completion pulse
//  irq_mtimecmp  out  1       registered (mtime >= mtimecmp)
//  imem_addr     out  RAM_AW  = im_addr[RAM_AW+1:2]
//  imem_rdata    in   32      sync-read instruction RAM data
//  dmem_addr     out  RAM_AW  = dm_addr[RAM_AW+1:2]
//  dmem_wdata    out  32      lane-replicated store data
//  dmem_wbe      out  4       RAM byte write enables
//  dmem_rdata    in   32      sync-read data RAM data
//  gpio_out      out  8       MMIO output register
// BEHAVIOUR
//  Reset: boot=0, fence_i_done=0, irq_mtimecmp=0, gpio_out=0, mtime=0,
//   mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, registered load selectors cleared (dm_do=0).
//  Address map: dm_addr[31]=0 -> data RAM. 0x8000_0000/04 mtime lo/hi,
//   0x8000_0008/0C mtimecmp lo/hi, 0x8000_0010 gpio (bits 7:0). Other MMIO:
//   reads return 0, writes are ignored.
//  Store: dmem_wbe = dm_be when dm_we & RAM region, else 0. dmem_wdata: byte
//   {4{dm_di[7:0]}}, half {2{dm_di[15:0]}}, word dm_di.
//  MMIO writes apply only when dm_be==4'b1111; partial MMIO stores are ignored.
//  Load: register addr[1:0], dm_be, is_signed, region and MMIO read value at the FD edge.
//   Next cycle dm_do = selected word >> (8*addr[1:0]), zero/sign-extended.
//   Width from be: 0001/0010/0100/1000 byte, 0011/1100 half, 1111 word;
//   any other pattern -> 0.
//  Timer: mtime += 1 every TICK_DIV cycles (64-bit, wraps to 0). A software write to a
//   mtime half wins over the increment in the same cycle.
//   irq_mtimecmp <= (mtime >= mtimecmp), unsigned, 1-cycle lag.
//  Boot: counter runs from reset release; boot rises after BOOT_DELAY cycles and stays
//   high until reset.
//  Fence FSM: IDLE -(fence_i & boot)-> FLUSH (FENCE_CYCLES cycles) -> DONE
//   (fence_i_done=1, exactly one cycle) -> IDLE.
//   - fence_i dropping in FLUSH: still completes.
//   - fence_i high in IDLE right after DONE: new fence, restarts FLUSH.
//   - reset in any state: IDLE.
//  Stores issued during FLUSH complete normally. An instruction-RAM write path is
//   outside this block.
// STRUCTURE
//  mmu_pkg: address-map constants, MMIO offsets, fence FSM state encoding.
//  Sub-module mmu_timer: mtime/mtimecmp registers, divider, irq compare.
//  Load align/extend and fence FSM stay in mmu.
// TESTING
//  1. Reset, BOOT_DELAY=16: boot=0 for 16 cycles after resetb rises, then 1.
//     All outputs at reset values.
//  2. Store be=0100 addr 0x102 di=0x000000A5 -> dmem_wbe=0100, wdata=0xA5A5A5A5.
//     Load be=0100 signed, rdata 0x00A50000 -> dm_do=0xFFFFFFA5; unsigned -> 0x000000A5.
//  3. Load be=1100 signed, rdata 0x80010000 -> dm_do=0xFFFF8001. be=0110 -> dm_do=0.
//  4. Write mtimecmp lo=10, hi=0; mtime from 0, TICK_DIV=1.
//     irq_mtimecmp rises the cycle after mtime reaches 10. Write hi=1 -> irq drops.
//  5. fence_i pulse held, FENCE_CYCLES=2 -> done 3 cycles after entry, width 1.
//     Back-to-back fence_i -> second done after another 3 cycles.
//  6. Reset asserted in FLUSH -> done never pulses; FSM IDLE. gpio write 0x5A word -> gpio_out=0x5A.

Source files
------------

// File: rtl/mmu_pkg.sv
// ============================================================================
// Module : mmu_pkg
// Brief  : MMIO address map and fence FSM state encoding for the mmu block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mmu_pkg;

  localparam logic [31:0] c_ADDR_MTIME_LO    = 32'h8000_0000;
  localparam logic [31:0] c_ADDR_MTIME_HI    = 32'h8000_0004;
  localparam logic [31:0] c_ADDR_MTIMECMP_LO = 32'h8000_0008;
  localparam logic [31:0] c_ADDR_MTIMECMP_HI = 32'h8000_000C;
  localparam logic [31:0] c_ADDR_GPIO        = 32'h8000_0010;

  typedef enum logic [1:0] {
    FENCE_IDLE  = 2'd0,
    FENCE_FLUSH = 2'd1,
    FENCE_DONE  = 2'd2
  } fence_state_t;

endpackage

`default_nettype wire

// File: rtl/mmu_timer.sv
// ============================================================================
// Module : mmu_timer
// Brief  : Machine timer: divided mtime counter, mtimecmp and registered irq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmu_timer
  import mmu_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [31:0] wdata,
  input  logic        wr_mtime_lo,
  input  logic        wr_mtime_hi,
  input  logic        wr_cmp_lo,
  input  logic        wr_cmp_hi,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        irq
);

  localparam int c_DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [c_DW-1:0] r_div;
  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;
  logic            r_irq;
  logic            w_tick;

  assign w_tick = (r_div == c_DW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_div <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  // A software write to either mtime half suppresses that cycle's increment.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_irq      <= 1'b0;
    end else begin
      if (wr_mtime_lo || wr_mtime_hi) begin
        if (wr_mtime_lo) r_mtime[31:0]  <= wdata;
        if (wr_mtime_hi) r_mtime[63:32] <= wdata;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (wr_cmp_lo) r_mtimecmp[31:0]  <= wdata;
      if (wr_cmp_hi) r_mtimecmp[63:32] <= wdata;
      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  assign mtime    = r_mtime;
  assign mtimecmp = r_mtimecmp;
  assign irq      = r_irq;

endmodule

`default_nettype wire

// File: rtl/mmu.sv
// ============================================================================
// Module : mmu
// Brief  : Core memory/IO unit: RAM routing, MMIO, load alignment, fence_i, boot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmu
  import mmu_pkg::*;
#(
  parameter int RAM_AW       = 12,
  parameter int BOOT_DELAY   = 16,
  parameter int FENCE_CYCLES = 2,
  parameter int TICK_DIV     = 1
) (
  input  logic              clk,
  input  logic              resetb,
  output logic              boot,
  input  logic [31:0]       im_addr,
  output logic [31:0]       im_do,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_di,
  input  logic [3:0]        dm_be,
  input  logic              dm_we,
  input  logic              dm_is_signed,
  output logic [31:0]       dm_do,
  input  logic              fence_i,
  output logic              fence_i_done,
  output logic              irq_mtimecmp,
  output logic [RAM_AW-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [RAM_AW-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wbe,
  input  logic [31:0]       dmem_rdata,
  output logic [7:0]        gpio_out
);

  localparam int c_FCW = (FENCE_CYCLES > 1) ? $clog2(FENCE_CYCLES) : 1;

  logic              w_mmio;
  logic              w_load;
  logic              w_mmio_wr;
  logic [31:0]       w_mmio_rdata;
  logic [63:0]       w_mtime;
  logic [63:0]       w_mtimecmp;
  logic              w_irq;
  logic [31:0]       w_ld_word;
  logic [31:0]       w_ld_shift;
  logic              w_unused_ok;

  logic [3:0]        r_ld_be;
  logic [1:0]        r_ld_off;
  logic              r_ld_signed;
  logic              r_ld_mmio;
  logic [31:0]       r_ld_mmio_data;
  logic [7:0]        r_gpio;
  logic [15:0]       r_boot_cnt;
  logic              r_boot;
  fence_state_t      r_fence_state;
  logic [c_FCW-1:0]  r_fence_cnt;
  logic              r_fence_done;

  assign w_unused_ok = &{1'b0, im_addr[31:RAM_AW+2], im_addr[1:0]};

  assign imem_addr = im_addr[RAM_AW+1:2];
  assign im_do     = imem_rdata;
  assign dmem_addr = dm_addr[RAM_AW+1:2];

  assign w_mmio    = dm_addr[31];
  assign w_load    = (dm_be != 4'b0000) && !dm_we;
  assign w_mmio_wr = dm_we && w_mmio && (dm_be == 4'b1111);

  assign dmem_wbe = (dm_we && !w_mmio) ? dm_be : 4'b0000;

  always_comb begin
    dmem_wdata = dm_di;
    case (dm_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: dmem_wdata = {4{dm_di[7:0]}};
      4'b0011, 4'b1100:                   dmem_wdata = {2{dm_di[15:0]}};
      default:                            dmem_wdata = dm_di;
    endcase
  end

  mmu_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk        (clk),
    .resetb     (resetb),
    .wdata      (dm_di),
    .wr_mtime_lo(w_mmio_wr && (dm_addr == c_ADDR_MTIME_LO)),
    .wr_mtime_hi(w_mmio_wr && (dm_addr == c_ADDR_MTIME_HI)),
    .wr_cmp_lo  (w_mmio_wr && (dm_addr == c_ADDR_MTIMECMP_LO)),
    .wr_cmp_hi  (w_mmio_wr && (dm_addr == c_ADDR_MTIMECMP_HI)),
    .mtime      (w_mtime),
    .mtimecmp   (w_mtimecmp),
    .irq        (w_irq)
  );

  assign irq_mtimecmp = w_irq;

  always_comb begin
    w_mmio_rdata = 32'd0;
    case (dm_addr)
      c_ADDR_MTIME_LO:    w_mmio_rdata = w_mtime[31:0];
      c_ADDR_MTIME_HI:    w_mmio_rdata = w_mtime[63:32];
      c_ADDR_MTIMECMP_LO: w_mmio_rdata = w_mtimecmp[31:0];
      c_ADDR_MTIMECMP_HI: w_mmio_rdata = w_mtimecmp[63:32];
      c_ADDR_GPIO:        w_mmio_rdata = {24'd0, r_gpio};
      default:            w_mmio_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_gpio <= 8'd0;
    end else if (w_mmio_wr && (dm_addr == c_ADDR_GPIO)) begin
      r_gpio <= dm_di[7:0];
    end
  end

  assign gpio_out = r_gpio;

  // Non-load cycles clear the lane mask so dm_do reads back as zero.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_ld_be        <= 4'b0000;
      r_ld_off       <= 2'b00;
      r_ld_signed    <= 1'b0;
      r_ld_mmio      <= 1'b0;
      r_ld_mmio_data <= 32'd0;
    end else begin
      r_ld_be        <= w_load ? dm_be : 4'b0000;
      r_ld_off       <= dm_addr[1:0];
      r_ld_signed    <= dm_is_signed;
      r_ld_mmio      <= w_mmio;
      r_ld_mmio_data <= w_mmio_rdata;
    end
  end

  assign w_ld_word  = r_ld_mmio ? r_ld_mmio_data : dmem_rdata;
  assign w_ld_shift = w_ld_word >> {r_ld_off, 3'b000};

  always_comb begin
    dm_do = 32'd0;
    case (r_ld_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        dm_do = {{24{r_ld_signed & w_ld_shift[7]}}, w_ld_shift[7:0]};
      4'b0011, 4'b1100:
        dm_do = {{16{r_ld_signed & w_ld_shift[15]}}, w_ld_shift[15:0]};
      4'b1111:
        dm_do = w_ld_shift;
      default:
        dm_do = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_boot_cnt <= 16'd0;
      r_boot     <= 1'b0;
    end else if (!r_boot) begin
      if (r_boot_cnt == 16'(BOOT_DELAY - 1)) begin
        r_boot <= 1'b1;
      end else begin
        r_boot_cnt <= r_boot_cnt + 16'd1;
      end
    end
  end

  assign boot = r_boot;

  // DONE always returns to IDLE, so a held fence_i re-arms a fresh flush.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_fence_state <= FENCE_IDLE;
      r_fence_cnt   <= '0;
      r_fence_done  <= 1'b0;
    end else begin
      r_fence_done <= 1'b0;
      case (r_fence_state)
        FENCE_IDLE: begin
          if (fence_i && r_boot) begin
            r_fence_state <= FENCE_FLUSH;
            r_fence_cnt   <= '0;
          end
        end
        FENCE_FLUSH: begin
          if (r_fence_cnt == c_FCW'(FENCE_CYCLES - 1)) begin
            r_fence_state <= FENCE_DONE;
            r_fence_done  <= 1'b1;
          end else begin
            r_fence_cnt <= r_fence_cnt + 1'b1;
          end
        end
        FENCE_DONE: r_fence_state <= FENCE_IDLE;
        default:    r_fence_state <= FENCE_IDLE;
      endcase
    end
  end

  assign fence_i_done = r_fence_done;

endmodule

`default_nettype wire

// File: tb/tb_mmu.sv
// ============================================================================
// Module : tb_mmu
// Brief  : Self-checking bench for mmu with RAM models and expectation queues.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmu;

  localparam int RAM_AW       = 12;
  localparam int BOOT_DELAY   = 16;
  localparam int FENCE_CYCLES = 2;
  localparam int TICK_DIV     = 1;

  logic              clk = 1'b0;
  logic              resetb = 1'b0;
  logic              boot;
  logic [31:0]       im_addr = 32'd0;
  logic [31:0]       im_do;
  logic [31:0]       dm_addr = 32'd0;
  logic [31:0]       dm_di = 32'd0;
  logic [3:0]        dm_be = 4'd0;
  logic              dm_we = 1'b0;
  logic              dm_is_signed = 1'b0;
  logic [31:0]       dm_do;
  logic              fence_i = 1'b0;
  logic              fence_i_done;
  logic              irq_mtimecmp;
  logic [RAM_AW-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [RAM_AW-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_wbe;
  logic [31:0]       dmem_rdata;
  logic [7:0]        gpio_out;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] q_exp[$];
  logic [31:0] got;

  mmu #(
    .RAM_AW      (RAM_AW),
    .BOOT_DELAY  (BOOT_DELAY),
    .FENCE_CYCLES(FENCE_CYCLES),
    .TICK_DIV    (TICK_DIV)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .boot        (boot),
    .im_addr     (im_addr),
    .im_do       (im_do),
    .dm_addr     (dm_addr),
    .dm_di       (dm_di),
    .dm_be       (dm_be),
    .dm_we       (dm_we),
    .dm_is_signed(dm_is_signed),
    .dm_do       (dm_do),
    .fence_i     (fence_i),
    .fence_i_done(fence_i_done),
    .irq_mtimecmp(irq_mtimecmp),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wbe    (dmem_wbe),
    .dmem_rdata  (dmem_rdata),
    .gpio_out    (gpio_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM models behind the DUT's RAM ports.
  logic [31:0] dmem [0:(1<<RAM_AW)-1];
  logic [31:0] imem [0:15];

  function automatic logic [31:0] imem_val(input int i);
    return 32'hC0DE_0000 | (32'(i) * 32'h0000_0101);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = imem_val(i);
  end

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dmem_wbe[b]) dmem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
    dmem_rdata <= dmem[dmem_addr];
    imem_rdata <= imem[imem_addr[3:0]];
  end

  task automatic bus_idle();
    dm_be = 4'd0; dm_we = 1'b0; dm_is_signed = 1'b0; dm_di = 32'd0; dm_addr = 32'd0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    dm_addr = a; dm_be = be; dm_we = 1'b1; dm_di = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    n_total++; if (boot !== 1'b0) $display("FAIL reset_boot got=%b want=0", boot); else n_pass++;
    n_total++; if (fence_i_done !== 1'b0) $display("FAIL reset_done got=%b want=0", fence_i_done); else n_pass++;
    n_total++; if (irq_mtimecmp !== 1'b0) $display("FAIL reset_irq got=%b want=0", irq_mtimecmp); else n_pass++;
    n_total++; if (gpio_out !== 8'h00) $display("FAIL reset_gpio got=%h want=00", gpio_out); else n_pass++;
    n_total++; if (dm_do !== 32'd0) $display("FAIL reset_dm_do got=%h want=0", dm_do); else n_pass++;
    resetb = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_total++;
      if (boot !== (k >= BOOT_DELAY))
        $display("FAIL boot_delay cycle=%0d got=%b want=%b", k, boot, (k >= BOOT_DELAY));
      else n_pass++;
    end
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 4; i++) begin
      im_addr = 32'(4 * (i * 3 + 1));
      #1;
      n_total++;
      if (imem_addr !== 12'(i * 3 + 1)) $display("FAIL fetch_addr got=%h want=%h", imem_addr, 12'(i * 3 + 1));
      else n_pass++;
      q_exp.push_back(imem_val(i * 3 + 1));
      @(negedge clk);
      got = q_exp.pop_front();
      n_total++; if (im_do !== got) $display("FAIL fetch_data got=%h want=%h", im_do, got); else n_pass++;
    end
  endtask

  task automatic test_store();
    bus_write(32'h100, 4'b1111, 32'h0000_0000);
    bus_write(32'h200, 4'b1111, 32'h8001_0000);
    bus_write(32'h204, 4'b1111, 32'h1234_5678);
    bus_write(32'h300, 4'b1111, 32'h0000_0000);
    dm_addr = 32'h102; dm_be = 4'b0100; dm_we = 1'b1; dm_di = 32'h0000_00A5;
    #1;
    n_total++; if (dmem_wbe !== 4'b0100) $display("FAIL st_byte_wbe got=%b want=0100", dmem_wbe); else n_pass++;
    n_total++; if (dmem_wdata !== 32'hA5A5_A5A5) $display("FAIL st_byte_wdata got=%h want=a5a5a5a5", dmem_wdata); else n_pass++;
    n_total++; if (dmem_addr !== 12'h040) $display("FAIL st_byte_addr got=%h want=040", dmem_addr); else n_pass++;
    @(negedge clk);
    dm_addr = 32'h302; dm_be = 4'b1100; dm_di = 32'h0000_BEEF;
    #1;
    n_total++; if (dmem_wbe !== 4'b1100) $display("FAIL st_half_wbe got=%b want=1100", dmem_wbe); else n_pass++;
    n_total++; if (dmem_wdata !== 32'hBEEF_BEEF) $display("FAIL st_half_wdata got=%h want=beefbeef", dmem_wdata); else n_pass++;
    @(negedge clk);
    bus_idle();
  endtask

  logic [31:0] t_addr [11] = '{32'h102, 32'h102, 32'h202, 32'h202, 32'h201, 32'h204,
                               32'h207, 32'h204, 32'h203, 32'h300, 32'h206};
  logic [3:0]  t_be   [11] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b0110, 4'b1111,
                               4'b1000, 4'b0011, 4'b1000, 4'b1111, 4'b0100};
  logic        t_sgn  [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] t_exp  [11] = '{32'hFFFF_FFA5, 32'h0000_00A5, 32'hFFFF_8001, 32'h0000_8001,
                               32'h0000_0000, 32'h1234_5678, 32'h0000_0012, 32'h0000_5678,
                               32'hFFFF_FF80, 32'hBEEF_0000, 32'h0000_0034};

  task automatic test_loads();
    for (int i = 0; i < 11; i++) begin
      dm_addr = t_addr[i]; dm_be = t_be[i]; dm_we = 1'b0; dm_is_signed = t_sgn[i];
      q_exp.push_back(t_exp[i]);
      @(negedge clk);
      got = q_exp.pop_front();
      n_total++;
      if (dm_do !== got) $display("FAIL load[%0d] addr=%h be=%b got=%h want=%h", i, t_addr[i], t_be[i], dm_do, got);
      else n_pass++;
    end
    bus_idle();
  endtask

  task automatic test_timer();
    logic [63:0] m_mt;
    logic        m_irq;
    bus_write(32'h8000_0004, 4'b1111, 32'd0);
    bus_write(32'h8000_0000, 4'b1111, 32'd0);
    bus_write(32'h8000_000C, 4'b1111, 32'd0);
    bus_write(32'h8000_0008, 4'b1111, 32'd10);
    m_mt  = 64'd2;
    m_irq = 1'b0;
    for (int i = 0; i < 14; i++) begin
      n_total++;
      if (irq_mtimecmp !== m_irq) $display("FAIL timer_irq mtime=%0d got=%b want=%b", m_mt, irq_mtimecmp, m_irq);
      else n_pass++;
      if (q_exp.size() > 0) begin
        got = q_exp.pop_front();
        n_total++; if (dm_do !== got) $display("FAIL timer_read got=%h want=%h", dm_do, got); else n_pass++;
      end
      if (i == 3) begin
        dm_addr = 32'h8000_0000; dm_be = 4'b1111; dm_we = 1'b0;
        q_exp.push_back(m_mt[31:0]);
      end else begin
        bus_idle();
      end
      @(posedge clk);
      m_irq = (m_mt >= 64'd10);
      m_mt  = m_mt + 64'd1;
      @(negedge clk);
    end
    bus_write(32'h8000_000C, 4'b1111, 32'd1);
    n_total++; if (irq_mtimecmp !== 1'b1) $display("FAIL timer_irq_lag got=%b want=1", irq_mtimecmp); else n_pass++;
    @(negedge clk);
    n_total++; if (irq_mtimecmp !== 1'b0) $display("FAIL timer_irq_drop got=%b want=0", irq_mtimecmp); else n_pass++;
  endtask

  task automatic test_fence();
    fence_i = 1'b1;
    for (int j = 0; j < 6; j++) q_exp.push_back({31'd0, (j == 2)});
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      fence_i = 1'b0;
      got = q_exp.pop_front();
      n_total++; if (fence_i_done !== got[0]) $display("FAIL fence_pulse cyc=%0d got=%b want=%b", j, fence_i_done, got[0]); else n_pass++;
    end
    fence_i = 1'b1;
    for (int j = 0; j < 12; j++) q_exp.push_back({31'd0, (j == 2) || (j == 6)});
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 7) fence_i = 1'b0;
      got = q_exp.pop_front();
      n_total++; if (fence_i_done !== got[0]) $display("FAIL fence_b2b cyc=%0d got=%b want=%b", j, fence_i_done, got[0]); else n_pass++;
    end
  endtask

  task automatic test_mmio();
    dm_addr = 32'h8000_0010; dm_be = 4'b1111; dm_we = 1'b1; dm_di = 32'h0000_005A;
    #1;
    n_total++; if (dmem_wbe !== 4'b0000) $display("FAIL mmio_no_ram_wbe got=%b want=0000", dmem_wbe); else n_pass++;
    @(negedge clk);
    bus_idle();
    n_total++; if (gpio_out !== 8'h5A) $display("FAIL gpio_write got=%h want=5a", gpio_out); else n_pass++;
    bus_write(32'h8000_0010, 4'b0001, 32'h0000_00FF);
    n_total++; if (gpio_out !== 8'h5A) $display("FAIL gpio_partial got=%h want=5a", gpio_out); else n_pass++;
    dm_we = 1'b0;
    dm_addr = 32'h8000_0010; dm_be = 4'b1111; q_exp.push_back(32'h0000_005A);
    @(negedge clk);
    got = q_exp.pop_front();
    n_total++; if (dm_do !== got) $display("FAIL mmio_rd_gpio got=%h want=%h", dm_do, got); else n_pass++;
    dm_addr = 32'h8000_0020; dm_be = 4'b1111; q_exp.push_back(32'h0000_0000);
    @(negedge clk);
    got = q_exp.pop_front();
    n_total++; if (dm_do !== got) $display("FAIL mmio_rd_unmapped got=%h want=%h", dm_do, got); else n_pass++;
    dm_addr = 32'h8000_000C; dm_be = 4'b1111; q_exp.push_back(32'h0000_0001);
    @(negedge clk);
    got = q_exp.pop_front();
    n_total++; if (dm_do !== got) $display("FAIL mmio_rd_cmphi got=%h want=%h", dm_do, got); else n_pass++;
    dm_addr = 32'h8000_0010; dm_be = 4'b0001; q_exp.push_back(32'h0000_005A);
    @(negedge clk);
    got = q_exp.pop_front();
    n_total++; if (dm_do !== got) $display("FAIL mmio_rd_byte got=%h want=%h", dm_do, got); else n_pass++;
    bus_idle();
  endtask

  task automatic test_reset_in_flush();
    fence_i = 1'b1;
    @(negedge clk);
    fence_i = 1'b0;
    resetb  = 1'b0;
    @(negedge clk);
    resetb  = 1'b1;
    fence_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n_total++; if (fence_i_done !== 1'b0) $display("FAIL rst_flush_done cyc=%0d got=%b want=0", k, fence_i_done); else n_pass++;
      @(negedge clk);
      if (k == 4) fence_i = 1'b0;
    end
    n_total++; if (gpio_out !== 8'h00) $display("FAIL rst_gpio got=%h want=00", gpio_out); else n_pass++;
    n_total++; if (boot !== 1'b0) $display("FAIL rst_boot_low got=%b want=0", boot); else n_pass++;
    repeat (8) @(negedge clk);
    n_total++; if (boot !== 1'b1) $display("FAIL rst_boot_high got=%b want=1", boot); else n_pass++;
    n_total++; if (fence_i_done !== 1'b0) $display("FAIL rst_no_late_done got=%b want=0", fence_i_done); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_fetch();
    test_store();
    test_loads();
    test_timer();
    test_fence();
    test_mmio();
    test_reset_in_flush();
    n_total++;
    if (q_exp.size() != 0) $display("FAIL scoreboard_drain left=%0d want=0", q_exp.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
